// File: rtl/bus_pkg.sv
// Shared definitions for the data-memory bus: region decode geometry,
// slave index sizing and the read-return pipe stage record.
package bus_pkg;

    localparam int REGION_W   = 4;
    localparam int REGION_MSB = 31;
    localparam int MAX_SLV    = 8;

    // Width of a slave index: ceil(log2(n)), never less than one bit.
    function automatic int slv_idx_w(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    localparam int MAX_IDX_W = slv_idx_w(MAX_SLV);

    // One read-return pipe stage: valid, selected slave, internal decode error.
    typedef struct packed {
        logic                 vld;
        logic [MAX_IDX_W-1:0] idx;
        logic                 err;
    } ret_stage_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Region decoder: compares an address region nibble against every slave
// region. The lowest matching slave index wins; no match flags a miss.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int                             NUM_SLV    = 2,
    parameter logic [NUM_SLV*REGION_W-1:0]    SLV_REGION = 8'h90,
    parameter int                             IDX_W      = slv_idx_w(NUM_SLV)
) (
    input  logic [REGION_W-1:0] region,
    output logic [NUM_SLV-1:0]  onehot,
    output logic [IDX_W-1:0]    idx,
    output logic                miss
);

    // Priority match: scan from the top so the lowest matching index is left last.
    always_comb begin
        onehot = '0;
        idx    = '0;
        miss   = 1'b1;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (region == SLV_REGION[REGION_W*i +: REGION_W]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
                miss      = 1'b0;
            end else begin
                onehot = onehot;
            end
        end
    end

endmodule

// File: rtl/dmem_bus_router.sv
// Data-memory router between the core's split read/write port and NUM_SLV
// slaves. Request channels are combinational; read data returns through an
// RD_LAT-deep pipe that remembers which slave (or internal error) answers.
// Optional feature macro: BUS_DECERR_EN - when defined, unmapped accesses are
// absorbed internally with an error response and a dec_err pulse; otherwise
// they are routed to DEFAULT_SLV.
module dmem_bus_router
    import bus_pkg::*;
#(
    parameter int                          NUM_SLV     = 2,
    parameter logic [NUM_SLV*REGION_W-1:0] SLV_REGION  = 8'h90,
    parameter int                          RD_LAT      = 1,
    parameter int                          DEFAULT_SLV = 0
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  m_wready,
    output logic                  m_wvalid,
    input  logic [31:0]           m_waddr,
    input  logic [31:0]           m_wdata,
    input  logic [3:0]            m_wstrb,
    input  logic                  m_rready,
    output logic                  m_rvalid,
    input  logic [31:0]           m_raddr,
    output logic                  m_rresp,
    output logic [31:0]           m_rdata,
    output logic [NUM_SLV-1:0]    s_wready,
    input  logic [NUM_SLV-1:0]    s_wvalid,
    output logic [31:0]           s_waddr,
    output logic [31:0]           s_wdata,
    output logic [3:0]            s_wstrb,
    output logic [NUM_SLV-1:0]    s_rready,
    input  logic [NUM_SLV-1:0]    s_rvalid,
    output logic [31:0]           s_raddr,
    input  logic [NUM_SLV-1:0]    s_rresp,
    input  logic [NUM_SLV*32-1:0] s_rdata,
    output logic                  dec_err
);

    localparam int               IDX_W   = slv_idx_w(NUM_SLV);
    localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_SLV);

    logic [NUM_SLV-1:0] w_onehot_s, r_onehot_s;
    logic [IDX_W-1:0]   w_idx_s,    r_idx_s;
    logic               w_miss_s,   r_miss_s;

    logic [NUM_SLV-1:0] w_sel_oh_s,  r_sel_oh_s;
    logic [IDX_W-1:0]   w_sel_idx_s, r_sel_idx_s;
    logic               w_int_s,     r_int_s;
    logic               w_accept_s,  r_accept_s;

    ret_stage_t         stage_in_s;
    ret_stage_t         last_s;
    ret_stage_t         pipe_r [RD_LAT];
    logic               dec_err_r;
    logic [31:0]        rsel_data_s;
    logic               rsel_resp_s;

    bus_addr_decode #(
        .NUM_SLV    (NUM_SLV),
        .SLV_REGION (SLV_REGION),
        .IDX_W      (IDX_W)
    ) u_wdec (
        .region (m_waddr[REGION_MSB -: REGION_W]),
        .onehot (w_onehot_s),
        .idx    (w_idx_s),
        .miss   (w_miss_s)
    );

    bus_addr_decode #(
        .NUM_SLV    (NUM_SLV),
        .SLV_REGION (SLV_REGION),
        .IDX_W      (IDX_W)
    ) u_rdec (
        .region (m_raddr[REGION_MSB -: REGION_W]),
        .onehot (r_onehot_s),
        .idx    (r_idx_s),
        .miss   (r_miss_s)
    );

    // Miss policy: absorb internally, or redirect to the default slave.
    always_comb begin
`ifdef BUS_DECERR_EN
        w_int_s     = w_miss_s;
        w_sel_oh_s  = w_miss_s ? '0 : w_onehot_s;
        w_sel_idx_s = w_idx_s;
        r_int_s     = r_miss_s;
        r_sel_oh_s  = r_miss_s ? '0 : r_onehot_s;
        r_sel_idx_s = r_idx_s;
`else
        w_int_s     = 1'b0;
        w_sel_oh_s  = w_miss_s ? (NUM_SLV'(1) << DEFAULT_SLV) : w_onehot_s;
        w_sel_idx_s = w_miss_s ? DEF_IDX : w_idx_s;
        r_int_s     = 1'b0;
        r_sel_oh_s  = r_miss_s ? (NUM_SLV'(1) << DEFAULT_SLV) : r_onehot_s;
        r_sel_idx_s = r_miss_s ? DEF_IDX : r_idx_s;
`endif
    end

    // Write channel: steer the request to the selected slave and reflect its accept.
    always_comb begin
        s_wready = '0;
        if (m_wready) begin
            s_wready = w_sel_oh_s;
        end else begin
            s_wready = '0;
        end
        if (w_int_s) begin
            m_wvalid = 1'b1;
        end else begin
            m_wvalid = s_wvalid[w_sel_idx_s];
        end
    end

    // Read request channel: same steering as writes.
    always_comb begin
        s_rready = '0;
        if (m_rready) begin
            s_rready = r_sel_oh_s;
        end else begin
            s_rready = '0;
        end
        if (r_int_s) begin
            m_rvalid = 1'b1;
        end else begin
            m_rvalid = s_rvalid[r_sel_idx_s];
        end
    end

    assign s_waddr    = m_waddr;
    assign s_wdata    = m_wdata;
    assign s_wstrb    = m_wstrb;
    assign s_raddr    = m_raddr;
    assign w_accept_s = m_wready && m_wvalid;
    assign r_accept_s = m_rready && m_rvalid;

    // Stage-0 record for the current cycle: a bubble unless a read is accepted.
    always_comb begin
        stage_in_s = '0;
        if (r_accept_s) begin
            stage_in_s.vld = 1'b1;
            stage_in_s.idx = MAX_IDX_W'(r_sel_idx_s);
            stage_in_s.err = r_int_s;
        end else begin
            stage_in_s.vld = 1'b0;
        end
    end

    // Return pipe: free-running shift register, cleared on reset.
    always_ff @(posedge clk) begin
        if (resetb) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= stage_in_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Decode-error pulse: one cycle after any accepted internally-handled miss.
    always_ff @(posedge clk) begin
        if (resetb) begin
            dec_err_r <= 1'b0;
        end else begin
            dec_err_r <= (w_accept_s && w_int_s) || (r_accept_s && r_int_s);
        end
    end

    assign dec_err = dec_err_r;
    assign last_s  = pipe_r[RD_LAT-1];

    // Pick the answering slave's data/response named by the last stage.
    always_comb begin
        rsel_data_s = 32'h0000_0000;
        rsel_resp_s = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (last_s.idx == MAX_IDX_W'(i)) begin
                rsel_data_s = s_rdata[32*i +: 32];
                rsel_resp_s = s_rresp[i];
            end else begin
                rsel_data_s = rsel_data_s;
            end
        end
    end

    // Return mux: slave data, internal error, or idle values.
    always_comb begin
        m_rdata = 32'h0000_0000;
        m_rresp = 1'b1;
        if (last_s.vld && !last_s.err) begin
            m_rdata = rsel_data_s;
            m_rresp = rsel_resp_s;
        end else if (last_s.vld) begin
            m_rdata = 32'h0000_0000;
            m_rresp = 1'b0;
        end else begin
            m_rdata = 32'h0000_0000;
            m_rresp = 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_bus_router.sv
// Scoreboard bench for dmem_bus_router (NUM_SLV=2, regions 0x0/0x9, RD_LAT=2)
// plus a small second instance with overlapping regions.
module tb_dmem_bus_router;

    localparam int NS = 2;
    localparam int RL = 2;
`ifdef BUS_DECERR_EN
    localparam bit DECERR = 1'b1;
`else
    localparam bit DECERR = 1'b0;
`endif

    typedef struct {
        logic [31:0] d;
        logic        r;
    } exp_t;

    logic              clk = 1'b0;
    logic              resetb = 1'b1;
    logic              m_wready = 1'b0, m_wvalid;
    logic [31:0]       m_waddr = 32'h0, m_wdata = 32'h0;
    logic [3:0]        m_wstrb = 4'h0;
    logic              m_rready = 1'b0, m_rvalid, m_rresp;
    logic [31:0]       m_raddr = 32'h0, m_rdata;
    logic [NS-1:0]     s_wready, s_wvalid = '0, s_rready, s_rvalid = '0, s_rresp;
    logic [31:0]       s_waddr, s_wdata, s_raddr;
    logic [3:0]        s_wstrb;
    logic [NS*32-1:0]  s_rdata;
    logic              dec_err;

    // overlap instance signals
    logic              o_m_wready = 1'b0, o_m_wvalid, o_m_rready = 1'b0, o_m_rvalid, o_m_rresp, o_dec_err;
    logic [31:0]       o_m_waddr = 32'h0, o_m_raddr = 32'h0, o_m_rdata, o_s_waddr, o_s_wdata, o_s_raddr;
    logic [3:0]        o_s_wstrb;
    logic [NS-1:0]     o_s_wready, o_s_rready, o_s_wvalid = '0, o_s_rvalid = '0;
    logic [NS-1:0]     o_s_rresp = '0;
    logic [NS*32-1:0]  o_s_rdata = '0;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    logic exp_dec_prev = 1'b0;

    logic [31:0] sp_d [NS][RL];
    logic        sp_r [NS][RL];
    logic        sp_v [NS][RL];

    always #5 clk = ~clk;

    dmem_bus_router #(.NUM_SLV(NS), .SLV_REGION(8'h90), .RD_LAT(RL), .DEFAULT_SLV(0)) u_dut (
        .clk(clk), .resetb(resetb),
        .m_wready(m_wready), .m_wvalid(m_wvalid), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rready(m_rready), .m_rvalid(m_rvalid), .m_raddr(m_raddr), .m_rresp(m_rresp), .m_rdata(m_rdata),
        .s_wready(s_wready), .s_wvalid(s_wvalid), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rready(s_rready), .s_rvalid(s_rvalid), .s_raddr(s_raddr), .s_rresp(s_rresp), .s_rdata(s_rdata),
        .dec_err(dec_err)
    );

    dmem_bus_router #(.NUM_SLV(NS), .SLV_REGION(8'h99), .RD_LAT(1), .DEFAULT_SLV(0)) u_ovl (
        .clk(clk), .resetb(resetb),
        .m_wready(o_m_wready), .m_wvalid(o_m_wvalid), .m_waddr(o_m_waddr), .m_wdata(32'h0), .m_wstrb(4'h0),
        .m_rready(o_m_rready), .m_rvalid(o_m_rvalid), .m_raddr(o_m_raddr), .m_rresp(o_m_rresp), .m_rdata(o_m_rdata),
        .s_wready(o_s_wready), .s_wvalid(o_s_wvalid), .s_waddr(o_s_waddr), .s_wdata(o_s_wdata), .s_wstrb(o_s_wstrb),
        .s_rready(o_s_rready), .s_rvalid(o_s_rvalid), .s_raddr(o_s_raddr), .s_rresp(o_s_rresp), .s_rdata(o_s_rdata),
        .dec_err(o_dec_err)
    );

    // Reference decode for regions 0x0 (slave 0) and 0x9 (slave 1); -1 = unmapped.
    function automatic int model_dec(input logic [31:0] a);
        if (a[31:28] == 4'h0) return 0;
        else if (a[31:28] == 4'h9) return 1;
        else return -1;
    endfunction

    function automatic int eff_slave(input logic [31:0] a);
        int s;
        s = model_dec(a);
        if (!DECERR && s < 0) s = 0;
        return s;
    endfunction

    function automatic logic [31:0] sdata(input int s, input logic [31:0] a);
        return a ^ (32'h5A5A_0000 + 32'(s));
    endfunction

    function automatic logic sresp(input logic [31:0] a);
        return ~a[3];
    endfunction

    // Slave models: answer exactly RL cycles after their own accept.
    always @(posedge clk) begin
        for (int s = 0; s < NS; s++) begin
            for (int k = RL - 1; k > 0; k--) begin
                sp_d[s][k] <= sp_d[s][k-1];
                sp_r[s][k] <= sp_r[s][k-1];
                sp_v[s][k] <= sp_v[s][k-1];
            end
            sp_v[s][0] <= s_rready[s] && s_rvalid[s];
            sp_d[s][0] <= sdata(s, s_raddr);
            sp_r[s][0] <= sresp(s_raddr);
        end
    end

    always_comb begin
        s_rdata = '0;
        s_rresp = '0;
        for (int s = 0; s < NS; s++) begin
            s_rdata[32*s +: 32] = (sp_v[s][RL-1] === 1'b1) ? sp_d[s][RL-1] : (32'hBAD0_0000 | 32'(s));
            s_rresp[s]          = (sp_v[s][RL-1] === 1'b1) ? sp_r[s][RL-1] : 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check combinational outputs, return data and dec_err.
    task automatic step(input logic rd, input logic [31:0] ra, input logic [1:0] srv,
                        input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [1:0] swv);
        int         rs, ws;
        logic       exp_rv, exp_wv, racc, wacc;
        logic [1:0] exp_rr, exp_wr;
        exp_t       e, f;
        @(negedge clk);
        m_rready = rd; m_raddr = ra; s_rvalid = srv;
        m_wready = wr; m_waddr = wa; m_wdata = wd; m_wstrb = wd[3:0] ^ 4'hA; s_wvalid = swv;
        #1;
        rs = eff_slave(ra);
        ws = eff_slave(wa);
        exp_rr = (rd && rs >= 0) ? (2'b01 << rs) : 2'b00;
        exp_wr = (wr && ws >= 0) ? (2'b01 << ws) : 2'b00;
        exp_rv = (rs < 0) ? 1'b1 : srv[rs];
        exp_wv = (ws < 0) ? 1'b1 : swv[ws];
        chk("s_rready", 32'(s_rready), 32'(exp_rr));
        chk("m_rvalid", 32'(m_rvalid), 32'(exp_rv));
        chk("s_wready", 32'(s_wready), 32'(exp_wr));
        chk("m_wvalid", 32'(m_wvalid), 32'(exp_wv));
        chk("s_raddr", s_raddr, ra);
        chk("s_wdata", s_wdata, wd);
        chk("s_waddr", s_waddr, wa);
        chk("s_wstrb", 32'(s_wstrb), 32'(wd[3:0] ^ 4'hA));
        racc = rd && exp_rv;
        wacc = wr && exp_wv;
        if (exp_q.size() >= RL) begin
            f = exp_q.pop_front();
            chk("m_rdata", m_rdata, f.d);
            chk("m_rresp", 32'(m_rresp), 32'(f.r));
        end else begin
            chk("sb_depth", 32'(exp_q.size()), 32'(RL));
        end
        if (racc && rs >= 0) begin
            e.d = sdata(rs, ra); e.r = sresp(ra);
        end else if (racc) begin
            e.d = 32'h0; e.r = 1'b0;
        end else begin
            e.d = 32'h0; e.r = 1'b1;
        end
        exp_q.push_back(e);
        chk("dec_err", 32'(dec_err), 32'(exp_dec_prev));
        exp_dec_prev = DECERR && ((racc && model_dec(ra) < 0) || (wacc && model_dec(wa) < 0));
    endtask

    task automatic do_reset(input int n);
        exp_t idle;
        @(negedge clk);
        resetb = 1'b1; m_rready = 1'b0; m_wready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_rdata", m_rdata, 32'h0);
        chk("rst_rresp", 32'(m_rresp), 32'h1);
        chk("rst_dec_err", 32'(dec_err), 32'h0);
        @(negedge clk);
        resetb = 1'b0;
        exp_q.delete();
        idle.d = 32'h0; idle.r = 1'b1;
        for (int i = 0; i < RL; i++) exp_q.push_back(idle);
        exp_dec_prev = 1'b0;
    endtask

    initial begin
        logic [3:0]  nibs [4];
        logic [31:0] ra, wa;
        nibs[0] = 4'h0; nibs[1] = 4'h9; nibs[2] = 4'h5; nibs[3] = 4'hF;

        do_reset(2);
        // write hit
        step(1'b0, 32'h0, 2'b00, 1'b1, 32'h9000_0004, 32'hDEAD_BEEF, 2'b10);
        // write pending (target slave not ready)
        step(1'b0, 32'h0, 2'b00, 1'b1, 32'h9000_0008, 32'h1234_5678, 2'b01);
        // back-to-back reads across slaves
        step(1'b1, 32'h0000_0010, 2'b11, 1'b0, 32'h0, 32'h0, 2'b00);
        step(1'b1, 32'h9000_0000, 2'b11, 1'b0, 32'h0, 32'h0, 2'b00);
        // read held without accept, then address change and accept
        step(1'b1, 32'h9000_0040, 2'b01, 1'b0, 32'h0, 32'h0, 2'b00);
        step(1'b1, 32'h0000_0048, 2'b01, 1'b0, 32'h0, 32'h0, 2'b00);
        // read miss, then simultaneous read and write misses
        step(1'b1, 32'h5000_0000, 2'b11, 1'b0, 32'h0, 32'h0, 2'b00);
        step(1'b1, 32'h5000_0004, 2'b11, 1'b1, 32'h7000_0000, 32'hCAFE_0001, 2'b11);
        step(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00);
        step(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00);
        step(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00);
        // randomised traffic
        for (int i = 0; i < 60; i++) begin
            ra = {nibs[$urandom_range(0, 3)], 28'($urandom)};
            wa = {nibs[$urandom_range(0, 3)], 28'($urandom)};
            step(1'($urandom), ra, 2'($urandom), 1'($urandom), wa, $urandom, 2'($urandom));
        end
        step(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00);
        step(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00);
        // reset one cycle after a read accept: the return must never appear
        step(1'b1, 32'h9000_0020, 2'b11, 1'b0, 32'h0, 32'h0, 2'b00);
        do_reset(1);
        step(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00);
        step(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00);
        step(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00);

        // overlapping regions: slave 0 wins
        @(negedge clk);
        o_m_raddr = 32'h9123_4567; o_m_rready = 1'b1; o_s_rvalid = 2'b11;
        o_m_waddr = 32'h9ABC_0000; o_m_wready = 1'b1; o_s_wvalid = 2'b10;
        #1;
        chk("ovl_s_rready", 32'(o_s_rready), 32'h1);
        chk("ovl_s_wready", 32'(o_s_wready), 32'h1);
        chk("ovl_m_wvalid", 32'(o_m_wvalid), 32'h0);
        @(negedge clk);
        o_m_rready = 1'b0; o_m_wready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_bus_router.md
# dmem_bus_router

Parametrised data-memory router between the core's split write/read data port and `NUM_SLV` slaves (RAM, CLINT, further MMIO). Slaves are selected by `addr[31:28]` against a per-slave region vector. Read-return routing is pipelined, so slaves with `RD_LAT` cycles of read latency are supported. Unmapped accesses are either answered with a decode error or routed to a default slave.

## Interface
Parameters:
- `NUM_SLV`, 2: number of slaves, range 1..8.
- `SLV_REGION`, `8'h90`: packed `NUM_SLV*4` bits; slave i owns addresses with `addr[31:28] == SLV_REGION[4*i +: 4]`.
- `RD_LAT`, 1: cycles from read accept to read data, range 1..4.
- `DEFAULT_SLV`, 0: slave that receives unmapped accesses when decode error is compiled out.

Ports:
- `clk` in 1: clock.
- `resetb` in 1: reset. Synchronous, active-high; the name is kept for codebase consistency.
- `m_wready` in 1: master write request.
- `m_wvalid` out 1: write accepted.
- `m_waddr` in 32; `m_wdata` in 32; `m_wstrb` in 4.
- `m_rready` in 1: master read request.
- `m_rvalid` out 1: read accepted.
- `m_raddr` in 32.
- `m_rresp` out 1: read response OK (1) or error (0).
- `m_rdata` out 32.
- `s_wready` out NUM_SLV: one-hot write request.
- `s_wvalid` in NUM_SLV.
- `s_waddr` out 32; `s_wdata` out 32; `s_wstrb` out 4: broadcast to all slaves.
- `s_rready` out NUM_SLV: one-hot read request.
- `s_rvalid` in NUM_SLV.
- `s_raddr` out 32: broadcast.
- `s_rresp` in NUM_SLV.
- `s_rdata` in NUM_SLV*32: slave i occupies `[32*i +: 32]`.
- `dec_err` out 1: one-cycle pulse, registered.

## Operation
- **Decode.** Compare `addr[31:28]` against every region. On multiple matches the lowest index wins. No match is a miss.
- **Write channel.** Fully combinational.
  - `s_wready[sel] = m_wready`; all other bits 0.
  - `m_wvalid = s_wvalid[sel]`.
  - Write miss with decode error enabled: no `s_wready` bit set, `m_wvalid = 1` (write dropped).
- **Read request.** Same as write: `s_rready[sel] = m_rready`, `m_rvalid = s_rvalid[sel]`. A read miss with decode error enabled is accepted internally (`m_rvalid = 1`).
- **Return pipe.** `RD_LAT` stages, each holding `{vld, idx, err}`.
  - Stage 0 loads on accept (`m_rready && m_rvalid`), otherwise loads `vld = 0`.
  - The pipe shifts every cycle; it has no stall.
- **Return mux.** Driven from the last stage.
  - `vld && !err`: `m_rdata = s_rdata[idx]`, `m_rresp = s_rresp[idx]`.
  - `vld && err`: `m_rdata = 0`, `m_rresp = 0`.
  - `!vld`: `m_rdata = 0`, `m_rresp = 1`.
- **Error pulse.** `dec_err` is registered high the cycle after any accepted miss, read or write. Simultaneous read and write misses produce a single pulse.
- Read and write channels are independent and may both be accepted in the same cycle.

## Timing
- **Reset values.** Pipe `vld = 0`, `dec_err = 0`, `m_rdata = 0`, `m_rresp = 1`. Combinational outputs follow their inputs.
- **Read latency.** Data appears exactly `RD_LAT` cycles after the accept cycle. Back-to-back accepts return on back-to-back cycles, including to different slaves.
- **Slave requirement.** A slave must present its rdata/rresp exactly `RD_LAT` cycles after its accept.
- **Reset mid-operation.** In-flight returns are discarded; the output is idle values in the cycle after reset is asserted.
- **Mid-request address change.** If `m_raddr`/`m_waddr` change while ready is held without accept, re-decode happens immediately. No request is latched.

## Configuration
- **`BUS_DECERR_EN` defined.** Misses are handled internally: accepted, return `m_rresp = 0`/`m_rdata = 0`, and pulse `dec_err`.
- **`BUS_DECERR_EN` undefined.** Misses route to `DEFAULT_SLV` like a hit, `err` is never set, and `dec_err` is tied 0.

## Structure
- Shared package `bus_pkg` holds:
  - `REGION_W = 4`, `REGION_MSB = 31`.
  - `MAX_SLV = 8`.
  - The slave index width function (clog2, minimum 1).
  - The return-stage struct `{vld, idx, err}`.
- Sub-module `bus_addr_decode` (address → one-hot, index, miss), instantiated once per channel. The pipe and muxes stay in the top level.

## Test plan
- **Write hit.** `NUM_SLV=2`, `SLV_REGION=8'h90`, write to `0x9000_0004` data `0xDEADBEEF` with `s_wvalid[1]=1` → `s_wready=2'b10`, `m_wvalid=1` same cycle, `dec_err` stays 0.
- **Back-to-back reads across slaves.** `RD_LAT=2`, reads to `0x0000_0010` then `0x9000_0000` on consecutive cycles, slaves return `0x11` and `0x22` → `m_rdata` is `0x11` at t+2 and `0x22` at t+3, `m_rresp=1` both cycles.
- **Read miss, decode error on.** `BUS_DECERR_EN` defined, read `0x5000_0000` → `m_rvalid=1`, no `s_rready` set, `dec_err=1` at t+1, `m_rresp=0` and `m_rdata=0` at t+`RD_LAT`.
- **Read miss, decode error off.** Macro undefined, same read → `s_rready[0]=1`, data from slave 0 returned, `dec_err` stays 0.
- **Reset mid-read.** Reset asserted one cycle after a read accept with `RD_LAT=3` → no return ever observed; `m_rresp=1` and `m_rdata=0` afterwards.
- **Overlapping regions.** `SLV_REGION=8'h99`, access `0x9xxx_xxxx` → slave 0 selected.
